// File: rtl/hazard_unit.sv
// hazard_unit -- load-use hazard detector for the 5-stage MIPS pipeline.
//
// Sits between the IF/ID and ID/EX registers. When the instruction in EX
// is a load whose destination (rt) is read by the instruction in ID, the
// unit holds the PC and IF/ID register and asks for a bubble in ID/EX.
// Detection is purely combinational and has zero latency.
//
// Optional feature, selected by the macro HAZARD_STATS_EN:
//   defined   -> adds the stall_count output, a saturating count of the
//                stall cycles seen since reset.
//   undefined -> no stall_count port and no flops. clk is then unused and
//                is kept only so that both builds have the same interface.
//
// Parameters
//   CNT_W    width of the optional stall counter
//   OPC_LSB  LSB of the 6-bit opcode field within ifidOpcode
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   ifidOpcode   in   full instruction word held in IF/ID
//   idRs/idRt    in   rs/rt fields of the instruction in ID
//   exRt         in   rt (load destination) of the instruction in EX
//   EXmemtoReg   in   instruction in EX is a load
//   pcwrite      out  1 = PC and IF/ID update, 0 = hold
//   hazardflag   out  1 = zero the ID/EX control fields (bubble)
//   stall_count  out  stall cycles since reset (HAZARD_STATS_EN only)

module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int OPC_LSB = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ifidOpcode,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  exRt,
  input  logic        EXmemtoReg,
  output logic        pcwrite,
  output logic        hazardflag
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;

  logic [5:0] op;
  logic [5:0] funct;
  logic       use_rs;
  logic       use_rt;
  logic       stall;

  // Only the opcode and funct fields are decoded; the other instruction
  // bits (and clk in the default build) are intentionally unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, ifidOpcode};

  assign op    = ifidOpcode[OPC_LSB +: 6];
  assign funct = ifidOpcode[5:0];

  // Which source fields the ID instruction really reads. Anything not
  // listed (including unknown opcodes) is treated as reading rs only,
  // which is the safe choice for I-type ALU ops and loads.
  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        use_rt = 1'b1;
        // Shift-by-immediate forms use shamt, not rs.
        if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
          use_rs = 1'b0;
      end
      OP_J, OP_JAL, OP_LUI: use_rs = 1'b0;
      OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: use_rt = 1'b1;
      default: ;
    endcase
  end

  // $zero is never a real dependency, so exRt == 0 never stalls. rst_n
  // gates the result so the pipeline runs freely while in reset and
  // detection resumes in the same cycle reset is released.
  always_comb begin
    stall = rst_n && EXmemtoReg && (exRt != 5'd0) &&
            ((use_rs && (exRt == idRs)) || (use_rt && (exRt == idRt)));
  end

  assign pcwrite    = ~stall;
  assign hazardflag = stall;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed vectors with literal expectations,
// plus a per-cycle comparison against a rule-level model.

module tb_hazard_unit;

  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifidOpcode;
  logic [4:0]  idRs, idRt, exRt;
  logic        EXmemtoReg;
  logic        pcwrite, hazardflag;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .OPC_LSB(26)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ifidOpcode (ifidOpcode),
    .idRs       (idRs),
    .idRt       (idRt),
    .exRt       (exRt),
    .EXmemtoReg (EXmemtoReg),
    .pcwrite    (pcwrite),
    .hazardflag (hazardflag)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rule-level model: which fields an instruction reads, then compare.
  function automatic bit model_stall(input bit rst, input bit mem,
                                     input logic [31:0] ins,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] ex);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    bit rd_rs = !((op inside {2, 3, 15}) || (op == 0 && (fn inside {0, 2, 3})));
    bit rd_rt = (op inside {0, 4, 5, 'h28, 'h29, 'h2B});
    if (!rst || !mem || ex == 0) return 1'b0;
    return (rd_rs && rs == ex) || (rd_rt && rt == ex);
  endfunction

  function automatic logic [31:0] mk(input int op, input int fn);
    logic [31:0] w;
    w = 32'd0;
    w[31:26] = op[5:0];
    w[5:0]   = fn[5:0];
    return w;
  endfunction

  // Reference stall counter, saturating, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 0;
    else if (model_stall(rst_n, EXmemtoReg, ifidOpcode, idRs, idRt, exRt) && mcnt < CMAX)
      mcnt <= mcnt + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      bit s;
      s = model_stall(rst_n, EXmemtoReg, ifidOpcode, idRs, idRt, exRt);
      chk("model_pcwrite", pcwrite, !s);
      chk("model_hazardflag", hazardflag, s);
`ifdef HAZARD_STATS_EN
      chk("model_stall_count", stall_count, mcnt);
`endif
    end
  end

  // Drive one vector just after a rising edge, check literals mid-cycle.
  task automatic apply(input string name, input bit r, input bit mem,
                       input logic [31:0] ins, input int rs, input int rt,
                       input int ex, input bit exp_stall);
    @(posedge clk); #1;
    rst_n = r; EXmemtoReg = mem; ifidOpcode = ins;
    idRs = rs[4:0]; idRt = rt[4:0]; exRt = ex[4:0];
    @(negedge clk);
    chk({name, "_pcwrite"}, pcwrite, !exp_stall);
    chk({name, "_hazardflag"}, hazardflag, exp_stall);
  endtask

  localparam int ADD = 0, FADD = 'h20;

  initial begin
    rst_n = 1'b0; EXmemtoReg = 1'b0; ifidOpcode = 32'd0;
    idRs = 5'd0; idRt = 5'd0; exRt = 5'd0;

    apply("reset_masks",   0, 1, mk(ADD, FADD), 5, 0, 5, 0);
`ifdef HAZARD_STATS_EN
    chk("reset_count", stall_count, 0);
`endif
    apply("add_rs_hit",    1, 1, mk(ADD, FADD), 8, 9, 8, 1);
    apply("add_no_load",   1, 0, mk(ADD, FADD), 8, 9, 8, 0);
    apply("addi_rt_dest",  1, 1, mk('h08, 0),   4, 9, 9, 0);
    apply("sw_rt_hit",     1, 1, mk('h2B, 0),   4, 9, 9, 1);
    apply("zero_reg",      1, 1, mk(ADD, FADD), 0, 0, 0, 0);
    apply("j_no_rs",       1, 1, mk('h02, 0),   3, 0, 3, 0);
    apply("sll_rs_ignored",1, 1, mk(ADD, 0),    7, 2, 7, 0);
    apply("sll_rt_hit",    1, 1, mk(ADD, 0),    7, 2, 2, 1);
    apply("srl_rs_ignored",1, 1, mk(ADD, 2),    7, 2, 7, 0);
    apply("sra_rs_ignored",1, 1, mk(ADD, 3),    7, 2, 7, 0);
    apply("sllv_rs_hit",   1, 1, mk(ADD, 4),    7, 2, 7, 1);
    apply("lui_no_rs",     1, 1, mk('h0F, 0),   6, 6, 6, 0);
    apply("jal_no_rs",     1, 1, mk('h03, 0),   6, 1, 6, 0);
    apply("beq_rt_hit",    1, 1, mk('h04, 0),   1, 12, 12, 1);
    apply("bne_rs_hit",    1, 1, mk('h05, 0),   12, 1, 12, 1);
    apply("sb_rt_hit",     1, 1, mk('h28, 0),   1, 13, 13, 1);
    apply("sh_rt_hit",     1, 1, mk('h29, 0),   1, 14, 14, 1);
    apply("lw_rs_hit",     1, 1, mk('h23, 0),   8, 8, 8, 1);
    apply("unk_rt_only",   1, 1, mk('h3F, 0),   1, 17, 17, 0);
    apply("unk_rs_hit",    1, 1, mk('h3F, 0),   17, 1, 17, 1);
    apply("both_hit",      1, 1, mk(ADD, FADD), 10, 10, 10, 1);
    apply("no_match",      1, 1, mk(ADD, FADD), 10, 11, 31, 0);

`ifdef HAZARD_STATS_EN
    // Clear, then exactly three stall cycles.
    @(posedge clk); #1;
    rst_n = 1'b0; EXmemtoReg = 1'b0;
    @(negedge clk);
    chk("cleared", stall_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; EXmemtoReg = 1'b1; ifidOpcode = mk(ADD, FADD);
    idRs = 5'd8; idRt = 5'd9; exRt = 5'd8;
    repeat (3) @(posedge clk);
    #1 EXmemtoReg = 1'b0;
    @(negedge clk);
    chk("three_stalls", stall_count, 3);
    // Mid-cycle reset pulse clears asynchronously.
    #1 rst_n = 1'b0;
    #1 chk("async_clear", stall_count, 0);
    chk("async_pcwrite", pcwrite, 1);
    #1 rst_n = 1'b1;
    // Run into saturation.
    @(posedge clk); #1 EXmemtoReg = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("six_stalls", stall_count, 6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("saturated", stall_count, CMAX);
    @(posedge clk); #1 EXmemtoReg = 1'b0;
    @(negedge clk);
    chk("sat_hold", stall_count, CMAX);
`endif

    @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
